// File: rtl/escape_scheduler.sv
// escape_scheduler: issues pixel jobs into a fixed-latency escape stepper, recirculates them until escape or iteration cap
// A valid/count shadow pipeline rides alongside the stepper, which carries neither.
module escape_scheduler #(
    parameter int STEPPER_LATENCY = 4,
    parameter int MAX_ITER        = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_x0,
    input  logic [63:0] job_y0,
    input  logic [7:0]  job_row,
    input  logic [7:0]  job_col,
    output logic        step_valid,
    output logic [63:0] step_x0,
    output logic [63:0] step_y0,
    output logic [63:0] step_x,
    output logic [63:0] step_y,
    output logic [63:0] step_x2,
    output logic [63:0] step_y2,
    output logic [7:0]  step_row,
    output logic [7:0]  step_col,
    input  logic [63:0] ret_x0,
    input  logic [63:0] ret_y0,
    input  logic [63:0] ret_x,
    input  logic [63:0] ret_y,
    input  logic [63:0] ret_x2,
    input  logic [63:0] ret_y2,
    input  logic [7:0]  ret_row,
    input  logic [7:0]  ret_col,
    input  logic        ret_escaped,
    output logic        result_valid,
    output logic [7:0]  result_row,
    output logic [7:0]  result_col,
    output logic [15:0] result_iter,
    output logic        result_escaped,
    output logic [7:0]  inflight,
    output logic        idle
);
    localparam int L = STEPPER_LATENCY;

    logic [L-1:0] vld;
    logic [15:0]  cnt [L];
    logic         ret_valid, retire, recirc, accept;
    logic [15:0]  ret_count, next_iter, issue_count;

    assign ret_valid = vld[L-1];
    assign ret_count = cnt[L-1];
    // ret_count never exceeds MAX_ITER-1, so the 16-bit increment cannot wrap
    assign next_iter = ret_count + 16'd1;
    assign retire    = ret_valid && (ret_escaped || next_iter == 16'(MAX_ITER));
    assign recirc    = ret_valid && !retire;
    assign job_ready = !recirc;
    assign accept    = job_valid && job_ready && !reset;
    assign idle      = inflight == 8'd0;

    always_comb begin
        step_valid  = recirc || accept;
        step_x0     = recirc ? ret_x0  : job_x0;
        step_y0     = recirc ? ret_y0  : job_y0;
        step_x      = recirc ? ret_x   : 64'h0;
        step_y      = recirc ? ret_y   : 64'h0;
        step_x2     = recirc ? ret_x2  : 64'h0;
        step_y2     = recirc ? ret_y2  : 64'h0;
        step_row    = recirc ? ret_row : job_row;
        step_col    = recirc ? ret_col : job_col;
        issue_count = recirc ? next_iter : 16'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld          <= '0;
            for (int i = 0; i < L; i++) cnt[i] <= '0;
            inflight     <= '0;
            result_valid <= 1'b0;
        end else begin
            vld[0] <= step_valid;
            cnt[0] <= issue_count;
            for (int i = 1; i < L; i++) begin
                vld[i] <= vld[i-1];
                cnt[i] <= cnt[i-1];
            end
            inflight     <= inflight + 8'(accept) - 8'(retire);
            result_valid <= retire;
        end
    end

    always_ff @(posedge clock) begin
        if (retire) begin
            result_row     <= ret_row;
            result_col     <= ret_col;
            result_iter    <= next_iter;
            result_escaped <= ret_escaped;
        end
    end
endmodule

// File: tb/tb_escape_scheduler.sv
// tb_escape_scheduler: stub stepper (x counts steps, x0 holds the escape step N) plus a per-job timeline model
module tb_escape_scheduler;
    localparam int L = 4;
    localparam int MI = 8;

    logic clock = 0, reset = 1, job_valid = 0;
    logic [63:0] job_x0 = 0, job_y0 = 0;
    logic [7:0] job_row = 0, job_col = 0;
    logic job_ready, step_valid, ret_escaped, result_valid, result_escaped, idle;
    logic [63:0] step_x0, step_y0, step_x, step_y, step_x2, step_y2;
    logic [63:0] ret_x0, ret_y0, ret_x, ret_y, ret_x2, ret_y2;
    logic [7:0] step_row, step_col, ret_row, ret_col, result_row, result_col, inflight;
    logic [15:0] result_iter;

    escape_scheduler #(.STEPPER_LATENCY(L), .MAX_ITER(MI)) dut (
        .clock(clock), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_x0(job_x0), .job_y0(job_y0), .job_row(job_row), .job_col(job_col),
        .step_valid(step_valid), .step_x0(step_x0), .step_y0(step_y0), .step_x(step_x),
        .step_y(step_y), .step_x2(step_x2), .step_y2(step_y2), .step_row(step_row), .step_col(step_col),
        .ret_x0(ret_x0), .ret_y0(ret_y0), .ret_x(ret_x), .ret_y(ret_y), .ret_x2(ret_x2), .ret_y2(ret_y2),
        .ret_row(ret_row), .ret_col(ret_col), .ret_escaped(ret_escaped),
        .result_valid(result_valid), .result_row(result_row), .result_col(result_col),
        .result_iter(result_iter), .result_escaped(result_escaped), .inflight(inflight), .idle(idle));

    always #5 clock = ~clock;

    logic [63:0] sx0 [L], sy0 [L], sx [L], sy [L], sx2 [L], sy2 [L];
    logic [7:0]  srow [L], scol [L];
    always @(posedge clock) begin
        sx0[0] <= step_x0; sy0[0] <= step_y0; sx[0] <= step_x + 64'd1; sy[0] <= step_y;
        sx2[0] <= step_x2; sy2[0] <= step_y2; srow[0] <= step_row; scol[0] <= step_col;
        for (int i = 1; i < L; i++) begin
            sx0[i] <= sx0[i-1]; sy0[i] <= sy0[i-1]; sx[i] <= sx[i-1]; sy[i] <= sy[i-1];
            sx2[i] <= sx2[i-1]; sy2[i] <= sy2[i-1]; srow[i] <= srow[i-1]; scol[i] <= scol[i-1];
        end
    end
    assign ret_x0 = sx0[L-1]; assign ret_y0 = sy0[L-1]; assign ret_x = sx[L-1]; assign ret_y = sy[L-1];
    assign ret_x2 = sx2[L-1]; assign ret_y2 = sy2[L-1]; assign ret_row = srow[L-1]; assign ret_col = scol[L-1];
    assign ret_escaped = (ret_x0 != 0) && (ret_x >= ret_x0);

    typedef struct { int acc; logic [7:0] row; logic [7:0] col; int iter; bit esc; } job_t;
    typedef struct { logic [7:0] row; logic [7:0] col; int n; int iter; bit esc; int lat; } vec_t;

    job_t active[$], pend[$];
    int cyc = 0, errors = 0, checks = 0, res_cyc, acc_cyc, t0;
    bit accepted, got_res;
    logic [7:0] r_row, r_col;
    logic [15:0] r_iter;
    logic r_esc;
    vec_t tbl [5];

    function automatic int iter_of(int n); return (n == 0 || n > MI) ? MI : n; endfunction
    function automatic bit esc_of(int n); return n != 0 && n <= MI; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        int ri, rd;
        bit rec;
        job_t j;
        @(negedge clock);
        ri = -1; rd = 0; rec = 0; accepted = 0;
        if (reset) begin
            chk("rst_ready", job_ready, 1); chk("rst_step_valid", step_valid, 0);
            chk("rst_result_valid", result_valid, 0); chk("rst_inflight", inflight, 0); chk("rst_idle", idle, 1);
            active.delete(); pend.delete();
        end else begin
            foreach (active[i]) begin
                int d = cyc - active[i].acc;
                if (d > 0 && d % L == 0) begin ri = i; rd = d / L; rec = rd < active[i].iter; end
            end
            chk("job_ready", job_ready, !rec);
            chk("inflight", inflight, active.size());
            chk("idle", idle, active.size() == 0);
            if (pend.size() > 0 && pend[0].acc == cyc) begin
                j = pend.pop_front();
                chk("result_valid", result_valid, 1); chk("result_row", result_row, j.row);
                chk("result_col", result_col, j.col); chk("result_iter", result_iter, j.iter);
                chk("result_escaped", result_escaped, j.esc);
            end else chk("result_idle", result_valid, 0);
            accepted = job_valid && !rec;
            chk("step_valid", step_valid, rec || accepted);
            if (rec) begin
                chk("recirc_row", step_row, active[ri].row); chk("recirc_col", step_col, active[ri].col);
                chk("recirc_x", step_x, rd);
            end else if (accepted) begin
                chk("new_x0", step_x0, job_x0); chk("new_y0", step_y0, job_y0);
                chk("new_zero", step_x | step_y | step_x2 | step_y2, 0);
                chk("new_row", step_row, job_row); chk("new_col", step_col, job_col);
            end
            if (ri >= 0 && !rec) begin
                j = active[ri]; j.acc = cyc + 1; pend.push_back(j); active.delete(ri);
            end
            if (accepted) begin
                j.acc = cyc; j.row = job_row; j.col = job_col;
                j.iter = iter_of(int'(job_x0)); j.esc = esc_of(int'(job_x0));
                active.push_back(j);
            end
        end
        if (result_valid) begin
            got_res = 1; res_cyc = cyc; r_row = result_row; r_col = result_col; r_iter = result_iter; r_esc = result_escaped;
        end
        @(posedge clock); #1; cyc++;
    endtask

    task automatic set_job(input logic [7:0] row, input logic [7:0] col, input int n);
        job_valid = 1; job_row = row; job_col = col; job_x0 = 64'(n); job_y0 = {$urandom, $urandom};
    endtask

    task automatic run_single(input logic [7:0] row, input logic [7:0] col, input int n, input int iter, input bit esc, input int lat);
        set_job(row, col, n); got_res = 0; acc_cyc = cyc;
        tick();
        chk("single_accept", accepted, 1);
        job_valid = 0;
        for (int w = 0; w < 60 && !got_res; w++) tick();
        chk("single_timeout", got_res, 1);
        chk("single_row", r_row, row); chk("single_col", r_col, col);
        chk("single_iter", r_iter, iter); chk("single_esc", r_esc, esc);
        chk("single_latency", res_cyc - acc_cyc, lat);
    endtask

    initial begin
        tbl[0] = '{8'd42, 8'd24, 0, 8, 1'b0, 33};
        tbl[1] = '{8'd69, 8'd96, 3, 3, 1'b1, 13};
        tbl[2] = '{8'd7,  8'd7,  8, 8, 1'b1, 33};
        tbl[3] = '{8'd1,  8'd2,  1, 1, 1'b1, 5};
        tbl[4] = '{8'd3,  8'd4,  9, 8, 1'b0, 33};
        tick(); tick();
        reset = 0;
        tick();
        foreach (tbl[k]) run_single(tbl[k].row, tbl[k].col, tbl[k].n, tbl[k].iter, tbl[k].esc, tbl[k].lat);

        // four jobs fill the ring, the fifth waits for the first retire
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin set_job(8'(10 + k), 8'(k), 0); tick(); end
        set_job(8'd14, 8'd4, 0);
        chk("full_ready_low", job_ready, 0);
        chk("full_inflight", inflight, 4);
        accepted = 0;
        for (int w = 0; w < 100 && !accepted; w++) tick();
        job_valid = 0;
        chk("fifth_accept_cycle", cyc - 1, t0 + L * MI);
        chk("swap_inflight", inflight, 4);
        for (int w = 0; w < 40; w++) tick();

        for (int k = 0; k < 3; k++) begin set_job(8'(20 + k), 8'(k), 0); tick(); end
        job_valid = 0;
        for (int w = 0; w < 5; w++) tick();
        #2 reset = 1;
        tick();
        reset = 0;
        chk("post_rst_inflight", inflight, 0);
        chk("post_rst_idle", idle, 1);
        got_res = 0;
        for (int w = 0; w < 40; w++) tick();
        chk("no_ghost_result", got_res, 0);
        run_single(8'd201, 8'd102, 2, 2, 1'b1, 9);

        for (int w = 0; w < 800; w++) begin
            if ($urandom_range(0, 2) != 0) set_job(8'($urandom), 8'($urandom), int'($urandom_range(0, 10)));
            else job_valid = 0;
            tick();
        end
        job_valid = 0;
        for (int w = 0; w < 50; w++) tick();
        chk("drained_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
